ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 119 +++++++++++
 tb/tb_ps2_key_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 frame receiver with glitch filter, timeout and make/break/extended event decoding.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       extended,
    output logic       key_released,
    output logic       done_posedge,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic [1:0] clk_sync_q, dat_sync_q;
    logic filt_q, fall_q;
    logic [FW-1:0] fcnt_q;
    state_t state_q;
    logic [2:0] bcnt_q;
    logic [7:0] shift_q, key_code_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic par_q, ext_pend_q, brk_pend_q, ext_q, rel_q, done_q, err_q, din, timeout_d, frame_ok_d;
    assign din = dat_sync_q[1];
    assign tcnt_d = (state_q == IDLE || fall_q) ? '0 : tcnt_q + TW'(1);
    assign timeout_d = state_q != IDLE && !fall_q && tcnt_q == TW'(TIMEOUT_CYCLES - 2);
    assign frame_ok_d = din && (^shift_q ^ par_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q <= 1'b1;
            fcnt_q <= '0;
            fall_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            fall_q <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync_q[1];
                fcnt_q <= '0;
                fall_q <= filt_q;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcnt_q <= '0;
            shift_q <= '0;
            par_q <= 1'b0;
            tcnt_q <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            key_code_q <= '0;
            ext_q <= 1'b0;
            rel_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q <= 1'b0;
            tcnt_q <= tcnt_d;
            if (timeout_d) begin
                state_q <= IDLE;
                err_q <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (fall_q) begin
                case (state_q)
                    IDLE: begin
                        if (!din) state_q <= DATA;
                        bcnt_q <= '0;
                    end
                    DATA: begin
                        shift_q <= {din, shift_q[7:1]};
                        bcnt_q <= bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q <= din;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!frame_ok_d) begin
                            err_q <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_q <= 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_pend_q <= 1'b1;
                        end else begin
                            key_code_q <= shift_q;
                            ext_q <= ext_pend_q;
                            rel_q <= brk_pend_q;
                            done_q <= 1'b1;
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
    assign key_code = key_code_q;
    assign extended = ext_q;
    assign key_released = rel_q;
    assign done_posedge = done_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table-driven PS/2 frames plus hand sequences for timeout, glitch and mid-frame reset.
module tb_ps2_key_decoder;
    localparam int T = 300;
    localparam int FL = 4;
    localparam int HALF = 20;
    localparam int LAT = FL + 3;
    typedef struct {
        logic [7:0] b;
        bit bad_par;
        bit stop;
        int d_done;
        int d_err;
        logic [7:0] code;
        bit ext;
        bit rel;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key_code;
    logic extended, key_released, done_posedge, frame_err;
    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, done_hi = 0, err_cnt = 0, err_hi = 0, both = 0;
    logic done_prev = 1'b0, err_prev = 1'b0;
    vec_t tbl[20];
    ps2_key_decoder #(.TIMEOUT_CYCLES(T), .FILTER_LEN(FL)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .extended(extended), .key_released(key_released),
        .done_posedge(done_posedge), .frame_err(frame_err)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        done_hi <= done_hi + int'(done_posedge);
        err_hi <= err_hi + int'(frame_err);
        done_cnt <= done_cnt + int'(done_posedge && !done_prev);
        err_cnt <= err_cnt + int'(frame_err && !err_prev);
        both <= both + int'(done_posedge && frame_err);
        done_prev <= done_posedge;
        err_prev <= frame_err;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic ps2_bit(input bit b, input bit g, output int lat);
        ps2_data = b;
        if (g) begin
            cyc(5);
            ps2_clk = 1'b0;
            cyc(FL - 2);
            ps2_clk = 1'b1;
            cyc(HALF - 5 - (FL - 2));
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b0;
        lat = -1;
        for (int k = 1; k <= HALF; k++) begin
            cyc(1);
            if (lat < 0 && (done_posedge || frame_err)) lat = k;
        end
        ps2_clk = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int glitch_at, output int lat);
        logic [10:0] bits;
        bits = {stop, ~^b ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_at, lat);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask
    initial begin
        int lat, d0, e0, k;
        tbl[0]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[1]  = '{8'hF0, 0, 1, 0, 0, 8'h1C, 0, 0};
        tbl[2]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 1};
        tbl[3]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[4]  = '{8'hE0, 0, 1, 0, 0, 8'h1C, 0, 0};
        tbl[5]  = '{8'hF0, 0, 1, 0, 0, 8'h1C, 0, 0};
        tbl[6]  = '{8'h75, 0, 1, 1, 0, 8'h75, 1, 1};
        tbl[7]  = '{8'hF0, 0, 1, 0, 0, 8'h75, 1, 1};
        tbl[8]  = '{8'hF0, 0, 1, 0, 0, 8'h75, 1, 1};
        tbl[9]  = '{8'hE0, 0, 1, 0, 0, 8'h75, 1, 1};
        tbl[10] = '{8'hE0, 0, 1, 0, 0, 8'h75, 1, 1};
        tbl[11] = '{8'h6B, 0, 1, 1, 0, 8'h6B, 1, 1};
        tbl[12] = '{8'h74, 0, 1, 1, 0, 8'h74, 0, 0};
        tbl[13] = '{8'h74, 0, 1, 1, 0, 8'h74, 0, 0};
        tbl[14] = '{8'hF0, 0, 1, 0, 0, 8'h74, 0, 0};
        tbl[15] = '{8'h1C, 1, 1, 0, 1, 8'h74, 0, 0};
        tbl[16] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[17] = '{8'hE0, 0, 1, 0, 0, 8'h1C, 0, 0};
        tbl[18] = '{8'h29, 0, 0, 0, 1, 8'h1C, 0, 0};
        tbl[19] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0};
        cyc(3);
        chk("reset_outputs", {key_code, extended, key_released, done_posedge, frame_err}, 0);
        rst = 1'b0;
        cyc(HALF);
        for (int i = 0; i < 20; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].stop, -1, lat);
            chk($sformatf("row%0d_done", i), done_cnt - d0, tbl[i].d_done);
            chk($sformatf("row%0d_err", i), err_cnt - e0, tbl[i].d_err);
            chk($sformatf("row%0d_outputs", i), {key_code, extended, key_released}, {tbl[i].code, tbl[i].ext, tbl[i].rel});
            chk($sformatf("row%0d_latency", i), lat, (tbl[i].d_done + tbl[i].d_err) != 0 ? LAT : -1);
        end
        e0 = err_cnt;
        ps2_bit(1'b1, 1'b0, lat);
        cyc(HALF);
        chk("idle_data1_err", err_cnt - e0, 0);
        chk("idle_data1_pulse", lat, -1);
        e0 = err_cnt;
        d0 = done_cnt;
        ps2_bit(1'b0, 1'b0, lat);
        ps2_bit(1'b1, 1'b0, lat);
        ps2_bit(1'b0, 1'b0, lat);
        ps2_bit(1'b0, 1'b0, lat);
        ps2_data = 1'b1;
        cyc(HALF);
        ps2_clk = 1'b0;
        k = 0;
        while (!frame_err && k < T + 100) begin
            cyc(1);
            k++;
            if (k == HALF) ps2_clk = 1'b1;
        end
        ps2_clk = 1'b1;
        chk("timeout_latency", k, FL + 2 + T);
        cyc(HALF);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_done", done_cnt - d0, 0);
        chk("timeout_outputs", {key_code, extended, key_released}, {8'h29, 2'b00});
        send_frame(8'h29, 0, 1, -1, lat);
        chk("after_timeout_done", done_cnt - d0, 1);
        chk("after_timeout_outputs", {key_code, extended, key_released}, {8'h29, 2'b00});
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h4B, 0, 1, 5, lat);
        chk("glitch_done", done_cnt - d0, 1);
        chk("glitch_err", err_cnt - e0, 0);
        chk("glitch_outputs", {key_code, extended, key_released}, {8'h4B, 2'b00});
        send_frame(8'hF0, 0, 1, -1, lat);
        e0 = err_cnt;
        d0 = done_cnt;
        ps2_bit(1'b0, 1'b0, lat);
        ps2_bit(1'b0, 1'b0, lat);
        ps2_bit(1'b1, 1'b0, lat);
        ps2_data = 1'b1;
        rst = 1'b1;
        cyc(2);
        chk("midframe_rst_outputs", {key_code, extended, key_released, done_posedge, frame_err}, 0);
        rst = 1'b0;
        cyc(2 * HALF);
        chk("midframe_rst_err", err_cnt - e0, 0);
        send_frame(8'h5A, 0, 1, -1, lat);
        chk("after_rst_done", done_cnt - d0, 1);
        chk("after_rst_outputs", {key_code, extended, key_released}, {8'h5A, 2'b00});
        chk("after_rst_err", err_cnt - e0, 0);
        cyc(2);
        chk("done_width", done_hi, done_cnt);
        chk("err_width", err_hi, err_cnt);
        chk("done_err_overlap", both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
